pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the general successor to the fixed EX/MEM latch. It carries instruction, PC+4, destination register and LANES payload words of WIDTH bits, with an explicit valid bit. It supports hold (stall), squash (flush/kill), and interrupt squash with restart-PC capture through a pending/ack handshake. It also runs a stall watchdog. One instance sits between each pair of adjacent pipeline stages (D/E, E/M, M/W).

---
 rtl/pipe_stage_reg.sv | 69 ++++++
 tb/tb_pipe_stage_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with hold, squash, interrupt
// restart-PC capture (pending/ack handshake) and a saturating stall watchdog.
module pipe_stage_reg #(
  parameter int          WIDTH        = 32,
  parameter int          LANES        = 2,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000,
  parameter int          CNT_W        = 8,
  parameter int          MAX_STALL    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_in,
  input  logic                   flush_in,
  input  logic                   kill_in,
  input  logic                   irq_in,
  input  logic                   epc_ack,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  input  logic [31:0]            in_pc4,
  input  logic [4:0]             in_wreg,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc4,
  output logic [4:0]             out_wreg,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [31:0]            epc_out,
  output logic                   epc_pending,
  output logic                   irq_overrun,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic                   stall_timeout
);
  logic squash, hold, take, epc_busy;
  assign squash = irq_in | flush_in | kill_in;
  assign hold = stall_in & ~squash;
  assign take = ~squash & ~stall_in & in_valid;
  // an ack on the same edge frees the slot, so a simultaneous irq recaptures
  assign epc_busy = epc_pending & ~epc_ack;
  assign stall_timeout = stall_cycles >= CNT_W'(MAX_STALL);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_instr    <= BUBBLE_INSTR;
      out_pc4      <= '0;
      out_wreg     <= '0;
      out_data     <= '0;
      epc_out      <= '0;
      epc_pending  <= 1'b0;
      irq_overrun  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (!hold) begin
        out_valid <= take;
        out_instr <= take ? in_instr : BUBBLE_INSTR;
        out_pc4   <= take ? in_pc4 : '0;
        out_wreg  <= take ? in_wreg : '0;
        out_data  <= take ? in_data : '0;
      end
      stall_cycles <= hold ? stall_cycles + CNT_W'(~&stall_cycles) : '0;
      if (irq_in && !epc_busy) begin
        epc_out     <= in_valid ? in_pc4 - 32'd4 : out_pc4;
        epc_pending <= 1'b1;
      end else if (epc_ack) begin
        epc_pending <= 1'b0;
      end
      if (irq_in && epc_busy) irq_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table, directed corner sequences and randomized
// stimulus against a behavioural model of the stage register.
module tb_pipe_stage_reg;
  localparam logic [31:0] BUB = 32'h0000_0020;
  localparam int MAXS = 64;

  typedef struct {
    bit          stall, flush, kill, irq, ack, valid;
    logic [31:0] instr, pc4;
    logic [4:0]  wreg;
    logic [63:0] data;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc4;
    logic [4:0]  wreg;
    logic [63:0] data;
    logic [31:0] epc;
    logic        pend, ovr;
    int          cnt;
  } st_t;

  typedef struct {
    in_t i;
    st_t e;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic stall_in, flush_in, kill_in, irq_in, epc_ack, in_valid;
  logic [31:0] in_instr, in_pc4;
  logic [4:0]  in_wreg;
  logic [63:0] in_data;
  logic        out_valid;
  logic [31:0] out_instr, out_pc4;
  logic [4:0]  out_wreg;
  logic [63:0] out_data;
  logic [31:0] epc_out;
  logic        epc_pending, irq_overrun;
  logic [7:0]  stall_cycles;
  logic        stall_timeout;

  int n_chk = 0, n_pass = 0;
  st_t m;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .LANES(2), .BUBBLE_INSTR(BUB), .CNT_W(8), .MAX_STALL(MAXS)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in), .kill_in(kill_in),
    .irq_in(irq_in), .epc_ack(epc_ack), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc4(in_pc4), .in_wreg(in_wreg), .in_data(in_data), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc4(out_pc4), .out_wreg(out_wreg), .out_data(out_data),
    .epc_out(epc_out), .epc_pending(epc_pending), .irq_overrun(irq_overrun),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  function automatic in_t mk_in(bit st, bit fl, bit kl, bit iq, bit ak, bit v,
                                logic [31:0] ins, logic [31:0] pc, logic [4:0] w, logic [63:0] d);
    in_t x;
    x.stall = st; x.flush = fl; x.kill = kl; x.irq = iq; x.ack = ak; x.valid = v;
    x.instr = ins; x.pc4 = pc; x.wreg = w; x.data = d;
    return x;
  endfunction

  function automatic st_t mk_st(logic v, logic [31:0] ins, logic [31:0] pc, logic [4:0] w,
                                logic [63:0] d, logic [31:0] epc, logic pend, logic ovr, int cnt);
    st_t s;
    s.valid = v; s.instr = ins; s.pc4 = pc; s.wreg = w; s.data = d;
    s.epc = epc; s.pend = pend; s.ovr = ovr; s.cnt = cnt;
    return s;
  endfunction

  function automatic st_t bubble_of(st_t s);
    st_t b = mk_st(1'b0, BUB, 32'd0, 5'd0, 64'd0, s.epc, s.pend, s.ovr, 0);
    return b;
  endfunction

  // One clock edge worth of behaviour, taken straight from the stage rules.
  function automatic st_t model(st_t s, in_t x);
    st_t n = s;
    bit squash = x.irq || x.flush || x.kill;
    if (squash) n = bubble_of(s);
    else if (x.stall) n.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
    else if (x.valid) n = mk_st(1'b1, x.instr, x.pc4, x.wreg, x.data, s.epc, s.pend, s.ovr, 0);
    else n = bubble_of(s);
    if (x.irq) begin
      if (s.pend && !x.ack) n.ovr = 1'b1;
      else begin
        n.epc = x.valid ? 32'(x.pc4 - 32'd4) : s.pc4;
        n.pend = 1'b1;
      end
    end else if (x.ack) n.pend = 1'b0;
    return n;
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask

  task automatic cmp_st(string t, st_t e);
    chk({t, ".valid"}, 64'(out_valid), 64'(e.valid));
    chk({t, ".instr"}, 64'(out_instr), 64'(e.instr));
    chk({t, ".pc4"}, 64'(out_pc4), 64'(e.pc4));
    chk({t, ".wreg"}, 64'(out_wreg), 64'(e.wreg));
    chk({t, ".data"}, out_data, e.data);
    chk({t, ".epc"}, 64'(epc_out), 64'(e.epc));
    chk({t, ".pend"}, 64'(epc_pending), 64'(e.pend));
    chk({t, ".ovr"}, 64'(irq_overrun), 64'(e.ovr));
    chk({t, ".cnt"}, 64'(stall_cycles), 64'(e.cnt));
    chk({t, ".tmo"}, 64'(stall_timeout), 64'(e.cnt >= MAXS));
  endtask

  task automatic apply(in_t x);
    stall_in = x.stall; flush_in = x.flush; kill_in = x.kill; irq_in = x.irq;
    epc_ack = x.ack; in_valid = x.valid; in_instr = x.instr; in_pc4 = x.pc4;
    in_wreg = x.wreg; in_data = x.data;
  endtask

  task automatic step(in_t x);
    apply(x);
    m = model(m, x);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t rnd_in(bit allow_squash);
    in_t x;
    x.stall = ($urandom_range(0, 2) == 0);
    x.flush = allow_squash && ($urandom_range(0, 11) == 0);
    x.kill  = allow_squash && ($urandom_range(0, 15) == 0);
    x.irq   = allow_squash && ($urandom_range(0, 13) == 0);
    x.ack   = ($urandom_range(0, 3) == 0);
    x.valid = ($urandom_range(0, 4) != 0);
    x.instr = $urandom;
    x.pc4   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    x.wreg  = 5'($urandom);
    x.data  = {$urandom, $urandom};
    return x;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    st_t rst_st, b0;
    in_t x;
    rst_st = mk_st(1'b0, BUB, 32'd0, 5'd0, 64'd0, 32'd0, 1'b0, 1'b0, 0);
    b0 = rst_st;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    cmp_st("reset", rst_st);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m = rst_st;

    tv.push_back('{mk_in(0,0,0,0,0,1,32'h0232_4021,32'h3004,8,64'hDEAD_BEEF),
                   mk_st(1,32'h0232_4021,32'h3004,8,64'hDEAD_BEEF,0,0,0,0)});
    tv.push_back('{mk_in(1,0,0,0,0,1,32'h1111_1111,32'h5000,9,1),
                   mk_st(1,32'h0232_4021,32'h3004,8,64'hDEAD_BEEF,0,0,0,1)});
    tv.push_back('{mk_in(1,1,0,0,0,1,32'h2222_2222,32'h5004,10,2), b0});
    tv.push_back('{mk_in(1,0,0,0,0,1,32'h3333_3333,32'h5008,11,3),
                   mk_st(0,BUB,0,0,0,0,0,0,1)});
    tv.push_back('{mk_in(0,0,0,0,0,1,32'h0022_1820,32'h3008,3,64'h5),
                   mk_st(1,32'h0022_1820,32'h3008,3,64'h5,0,0,0,0)});
    tv.push_back('{mk_in(0,0,1,0,0,1,32'h4444_4444,32'h300C,4,4), b0});
    tv.push_back('{mk_in(0,0,0,0,0,0,32'h0000_AAAA,32'h1234,7,64'hFF), b0});
    tv.push_back('{mk_in(0,0,0,0,0,1,32'h8C43_0004,32'h300C,3,64'h0000_0077_0000_0066),
                   mk_st(1,32'h8C43_0004,32'h300C,3,64'h0000_0077_0000_0066,0,0,0,0)});
    tv.push_back('{mk_in(0,0,0,1,0,1,32'h5555_5555,32'h3010,5,5),
                   mk_st(0,BUB,0,0,0,32'h300C,1,0,0)});
    tv.push_back('{mk_in(0,0,0,1,0,1,32'h6666_6666,32'h4000,6,6),
                   mk_st(0,BUB,0,0,0,32'h300C,1,1,0)});
    tv.push_back('{mk_in(0,0,0,0,1,1,32'h7777_7777,32'h5004,1,7),
                   mk_st(1,32'h7777_7777,32'h5004,1,7,32'h300C,0,1,0)});
    tv.push_back('{mk_in(0,0,0,0,1,0,32'h8888_8888,32'h5008,2,8),
                   mk_st(0,BUB,0,0,0,32'h300C,0,1,0)});
    tv.push_back('{mk_in(0,0,0,1,0,0,0,0,0,0), mk_st(0,BUB,0,0,0,32'h0,1,1,0)});
    tv.push_back('{mk_in(0,0,0,1,1,1,32'h9999_9999,32'h0,0,0),
                   mk_st(0,BUB,0,0,0,32'hFFFF_FFFC,1,1,0)});
    tv.push_back('{mk_in(0,0,0,1,1,0,0,0,0,0), mk_st(0,BUB,0,0,0,32'h0,1,1,0)});
    tv.push_back('{mk_in(0,0,0,0,1,1,32'h1234_5678,32'h2468,2,3),
                   mk_st(1,32'h1234_5678,32'h2468,2,3,32'h0,0,1,0)});
    tv.push_back('{mk_in(0,0,0,1,0,0,0,0,0,0), mk_st(0,BUB,0,0,0,32'h2468,1,1,0)});
    tv.push_back('{mk_in(1,0,0,0,1,1,32'hABCD_0000,32'h7000,9,9),
                   mk_st(0,BUB,0,0,0,32'h2468,0,1,1)});
    foreach (tv[k]) begin
      step(tv[k].i);
      cmp_st($sformatf("vec%0d", k), tv[k].e);
    end

    // watchdog: 70 stalled edges, then a load, then saturation
    step(mk_in(0,0,0,0,0,1,32'h0BAD_F00D,32'h8004,17,64'h1234));
    for (int k = 1; k <= 70; k++) begin
      x = rnd_in(1'b0);
      x.stall = 1'b1;
      step(x);
      cmp_st($sformatf("stall%0d", k), m);
      chk($sformatf("stall%0d.instr_frozen", k), 64'(out_instr), 64'h0BAD_F00D);
      chk($sformatf("stall%0d.cnt_abs", k), 64'(stall_cycles), 64'(k));
      chk($sformatf("stall%0d.tmo_abs", k), 64'(stall_timeout), 64'(k >= 64));
    end
    step(mk_in(0,0,0,0,0,1,32'h1,32'h8008,1,64'h1));
    chk("wd_clear.cnt", 64'(stall_cycles), 64'd0);
    chk("wd_clear.tmo", 64'(stall_timeout), 64'd0);
    for (int k = 1; k <= 260; k++) begin
      x = rnd_in(1'b0);
      x.stall = 1'b1;
      step(x);
      cmp_st($sformatf("sat%0d", k), m);
    end
    chk("sat.cnt_abs", 64'(stall_cycles), 64'd255);

    // randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      step(rnd_in(1'b1));
      cmp_st($sformatf("rnd%0d", k), m);
    end

    // async reset mid-cycle while stalled with a pending capture
    step(mk_in(0,0,0,0,1,1,32'hCAFE_0001,32'h9004,4,64'h44));
    step(mk_in(0,0,0,1,0,1,32'hCAFE_0002,32'h9008,5,64'h55));
    step(mk_in(0,0,0,0,0,1,32'hCAFE_0003,32'h900C,6,64'h66));
    for (int k = 0; k < 3; k++) step(mk_in(1,0,0,0,0,1,32'hCAFE_0004,32'h9010,7,64'h77));
    chk("pre_rst.pend", 64'(epc_pending), 64'd1);
    chk("pre_rst.cnt", 64'(stall_cycles), 64'd3);
    #3;
    reset = 1'b1;
    #1;
    cmp_st("async_rst", rst_st);
    apply(mk_in(0,0,0,1,0,1,32'hCAFE_0005,32'h9014,8,64'h88));
    @(posedge clk);
    #1;
    cmp_st("rst_held", rst_st);
    #3;
    reset = 1'b0;
    m = rst_st;
    step(mk_in(0,0,0,0,0,1,32'hCAFE_0006,32'h9018,9,64'h99));
    cmp_st("post_rst", m);
    chk("post_rst.instr_abs", 64'(out_instr), 64'hCAFE_0006);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
